// File: rtl/present_pkg.sv
// Shared PRESENT key-schedule definitions: S-box, FSM states and the
// round-key register update used by the scheduler.
package present_pkg;

    localparam int RK_WIDTH = 64;

    // S-box outputs packed so that entry n sits at bits [4n+3:4n].
    localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_EXPAND     = 2'd1,
        ST_STREAM_FWD = 2'd2,
        ST_STREAM_REV = 2'd3
    } state_t;

    function automatic logic [3:0] present_sbox(input logic [3:0] nib);
        logic [63:0] table_v;
        table_v = SBOX;
        return table_v[{nib, 2'b00} +: 4];
    endfunction

    // One key-schedule step. An 80-bit key lives in key[79:0] with the upper
    // bits zero; wide selects the 128-bit variant.
    function automatic logic [127:0] present_key_update(input logic [127:0] key,
                                                        input logic [4:0]   counter,
                                                        input logic         wide);
        logic [127:0] k;
        if (wide) begin
            k = {key[66:0], key[127:67]};
            k[127:124] = present_sbox(k[127:124]);
            k[123:120] = present_sbox(k[123:120]);
            k[66:62]   = k[66:62] ^ counter;
        end else begin
            k = {key[127:80], key[18:0], key[79:19]};
            k[79:76] = present_sbox(k[79:76]);
            k[19:15] = k[19:15] ^ counter;
        end
        return k;
    endfunction

endpackage

// File: rtl/present_rk_buffer.sv
// Round-key store for the decryption path: one write port, one read port
// whose output register only changes when a read is requested.
module present_rk_buffer
    import present_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                we,
    input  logic [4:0]          waddr,
    input  logic [RK_WIDTH-1:0] wdata,
    input  logic                re,
    input  logic [4:0]          raddr,
    output logic [RK_WIDTH-1:0] rdata
);

    logic [RK_WIDTH-1:0] mem [DEPTH];
    logic [RK_WIDTH-1:0] rdata_r;

    // Storage array write; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value while no read is issued.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/present_key_scheduler.sv
// PRESENT key scheduler: expands an 80/128-bit key into ROUNDS round keys and
// streams them forward (encrypt) or, after buffering, in reverse (decrypt).
module present_key_scheduler
    import present_pkg::*;
#(
    parameter int KEY_WIDTH = 80,
    parameter int ROUNDS    = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [KEY_WIDTH-1:0] key_in,
    input  logic                 start,
    input  logic                 decrypt,
    output logic                 busy,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [RK_WIDTH-1:0]  rk_out,
    output logic [4:0]           rk_index,
    output logic                 rk_last
);

    localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);
    localparam logic       WIDE     = (KEY_WIDTH == 128) ? 1'b1 : 1'b0;

    if (!((KEY_WIDTH == 80) || (KEY_WIDTH == 128)) || (ROUNDS < 2) || (ROUNDS > 32)) begin : g_bad_param
        $error("present_key_scheduler: KEY_WIDTH must be 80/128 and ROUNDS 2..32");
    end

    state_t                state_r;
    logic [KEY_WIDTH-1:0]  key_r;
    logic [KEY_WIDTH-1:0]  key_next_s;
    logic [127:0]          key_wide_s;
    logic [127:0]          upd_wide_s;
    logic [RK_WIDTH-1:0]   rk_cur_s;
    logic [RK_WIDTH-1:0]   rk_fwd_r;
    logic [RK_WIDTH-1:0]   buf_rdata_s;
    logic [4:0]            rk_index_r;
    logic                  rk_valid_r;
    logic                  rk_last_r;
    logic                  busy_r;
    logic                  rev_sel_r;
    logic                  buf_we_s;
    logic                  buf_re_s;
    logic [4:0]            buf_raddr_s;

    // Next key register value; the step counter is the 1-based round number.
    always_comb begin
        key_wide_s                = '0;
        key_wide_s[KEY_WIDTH-1:0] = key_r;
        upd_wide_s                = present_key_update(key_wide_s, rk_index_r + 5'd1, WIDE);
    end

    if (KEY_WIDTH < 128) begin : g_narrow
        logic unused_upper;
        assign unused_upper = ^upd_wide_s[127:KEY_WIDTH];
    end

    assign key_next_s = upd_wide_s[KEY_WIDTH-1:0];
    assign rk_cur_s   = key_r[KEY_WIDTH-1 -: RK_WIDTH];

    // Buffer port control: write during expansion, read/prefetch in reverse.
    always_comb begin
        buf_we_s    = (state_r == ST_EXPAND);
        buf_re_s    = 1'b0;
        buf_raddr_s = LAST_IDX;
        if (state_r == ST_STREAM_REV) begin
            if (!rk_valid_r) begin
                buf_re_s    = 1'b1;
                buf_raddr_s = LAST_IDX;
            end else if (rk_ready && (rk_index_r != 5'd0)) begin
                buf_re_s    = 1'b1;
                buf_raddr_s = rk_index_r - 5'd1;
            end else begin
                buf_re_s    = 1'b0;
                buf_raddr_s = rk_index_r;
            end
        end else begin
            buf_re_s    = 1'b0;
            buf_raddr_s = LAST_IDX;
        end
    end

    present_rk_buffer #(
        .DEPTH (ROUNDS)
    ) u_rk_buffer (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (buf_we_s),
        .waddr   (rk_index_r),
        .wdata   (rk_cur_s),
        .re      (buf_re_s),
        .raddr   (buf_raddr_s),
        .rdata   (buf_rdata_s)
    );

    // Scheduler state machine with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            key_r      <= '0;
            rk_fwd_r   <= '0;
            rk_index_r <= 5'd0;
            rk_valid_r <= 1'b0;
            rk_last_r  <= 1'b0;
            busy_r     <= 1'b0;
            rev_sel_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        key_r      <= key_in;
                        rk_index_r <= 5'd0;
                        rk_valid_r <= 1'b0;
                        rk_last_r  <= 1'b0;
                        busy_r     <= 1'b1;
                        rev_sel_r  <= decrypt;
                        state_r    <= decrypt ? ST_EXPAND : ST_STREAM_FWD;
                    end
                end
                ST_EXPAND: begin
                    if (rk_index_r == LAST_IDX) begin
                        state_r <= ST_STREAM_REV;
                    end else begin
                        key_r      <= key_next_s;
                        rk_index_r <= rk_index_r + 5'd1;
                    end
                end
                ST_STREAM_FWD: begin
                    if (!rk_valid_r) begin
                        rk_fwd_r   <= rk_cur_s;
                        rk_valid_r <= 1'b1;
                        rk_last_r  <= 1'b0;
                    end else if (rk_ready) begin
                        if (rk_index_r == LAST_IDX) begin
                            rk_valid_r <= 1'b0;
                            rk_last_r  <= 1'b0;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            key_r      <= key_next_s;
                            rk_fwd_r   <= key_next_s[KEY_WIDTH-1 -: RK_WIDTH];
                            rk_index_r <= rk_index_r + 5'd1;
                            rk_last_r  <= ((rk_index_r + 5'd1) == LAST_IDX);
                        end
                    end
                end
                ST_STREAM_REV: begin
                    if (!rk_valid_r) begin
                        rk_valid_r <= 1'b1;
                        rk_index_r <= LAST_IDX;
                        rk_last_r  <= 1'b0;
                    end else if (rk_ready) begin
                        if (rk_index_r == 5'd0) begin
                            rk_valid_r <= 1'b0;
                            rk_last_r  <= 1'b0;
                            busy_r     <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            rk_index_r <= rk_index_r - 5'd1;
                            rk_last_r  <= (rk_index_r == 5'd1);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    rk_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign rk_valid = rk_valid_r;
    assign rk_index = rk_index_r;
    assign rk_last  = rk_last_r;
    assign rk_out   = rev_sel_r ? buf_rdata_s : rk_fwd_r;

endmodule

// File: tb/tb_present_key_scheduler.sv
// Directed bench for present_key_scheduler (80-bit and 128-bit instances).
module tb_present_key_scheduler;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [79:0]  key_a;
    logic         start_a, decrypt_a, ready_a;
    logic         busy_a, valid_a, last_a;
    logic [63:0]  out_a;
    logic [4:0]   idx_a;
    logic [127:0] key_b;
    logic         start_b, decrypt_b, ready_b;
    logic         busy_b, valid_b, last_b;
    logic [63:0]  out_b;
    logic [4:0]   idx_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    present_key_scheduler #(.KEY_WIDTH(80), .ROUNDS(32)) dut80 (
        .clock(clock), .reset_n(reset_n), .key_in(key_a), .start(start_a),
        .decrypt(decrypt_a), .busy(busy_a), .rk_valid(valid_a), .rk_ready(ready_a),
        .rk_out(out_a), .rk_index(idx_a), .rk_last(last_a)
    );

    present_key_scheduler #(.KEY_WIDTH(128), .ROUNDS(32)) dut128 (
        .clock(clock), .reset_n(reset_n), .key_in(key_b), .start(start_b),
        .decrypt(decrypt_b), .busy(busy_b), .rk_valid(valid_b), .rk_ready(ready_b),
        .rk_out(out_b), .rk_index(idx_b), .rk_last(last_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] mdl_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    // Reference step: bitwise rotation by 61, S-box, round-counter XOR.
    function automatic logic [127:0] mdl_step(input logic [127:0] k, input int kw, input int rnd);
        logic [127:0] r;
        logic [4:0]   c;
        r = '0;
        c = 5'(rnd);
        for (int b = 0; b < kw; b++) r[(b + 61) % kw] = k[b];
        if (kw == 80) begin
            r[79:76] = mdl_sbox(r[79:76]);
            r[19:15] = r[19:15] ^ c;
        end else begin
            r[127:124] = mdl_sbox(r[127:124]);
            r[123:120] = mdl_sbox(r[123:120]);
            r[66:62]   = r[66:62] ^ c;
        end
        return r;
    endfunction

    function automatic logic [63:0] mdl_rk(input int kw, input logic [127:0] key0, input int idx);
        logic [127:0] k;
        k = key0;
        for (int j = 1; j <= idx; j++) k = mdl_step(k, kw, j);
        return (kw == 80) ? k[79:16] : k[127:64];
    endfunction

    logic [63:0] saved_out;
    logic [4:0]  saved_idx;
    logic        prev_stall;
    logic        done;
    int          exp_idx;

    initial begin
        reset_n = 1'b0;
        key_a = '0; start_a = 1'b1; decrypt_a = 1'b0; ready_a = 1'b1;
        key_b = '0; start_b = 1'b1; decrypt_b = 1'b0; ready_b = 1'b1;

        // Reset held for three cycles with start asserted.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_busy",  64'(busy_a),  64'd0);
        chk("rst_out",   out_a,        64'd0);
        chk("rst_index", 64'(idx_a),   64'd0);
        chk("rst_last",  64'(last_a),  64'd0);
        chk("rst_valid128", 64'(valid_b), 64'd0);
        chk("rst_busy128",  64'(busy_b),  64'd0);
        start_a = 1'b0; start_b = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("idle_after_rst", 64'(busy_a), 64'd0);

        // 80-bit, key 0, forward, ready always high.
        start_a = 1'b1; decrypt_a = 1'b0; key_a = '0; ready_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        chk("fwd_busy", 64'(busy_a), 64'd1);
        for (int i = 0; i < 32; i++) begin
            @(posedge clock); #1;
            chk("fwd_valid", 64'(valid_a), 64'd1);
            chk("fwd_index", 64'(idx_a), 64'(i));
            chk("fwd_key",   out_a, mdl_rk(80, 128'd0, i));
            chk("fwd_last",  64'(last_a), (i == 31) ? 64'd1 : 64'd0);
            if (i == 0) chk("fwd_k1", out_a, 64'h0000000000000000);
            if (i == 1) chk("fwd_k2", out_a, 64'hC000000000000000);
            if (i == 2) chk("fwd_k3", out_a, 64'h5000180000000001);
        end
        @(posedge clock); #1;
        chk("fwd_end_valid", 64'(valid_a), 64'd0);
        chk("fwd_end_busy",  64'(busy_a),  64'd0);

        // Same run under random backpressure; stalled outputs must hold.
        start_a = 1'b1; ready_a = 1'b0;
        @(posedge clock); #1;
        start_a = 1'b0;
        exp_idx = 0; done = 1'b0; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(posedge clock); #1;
            if (prev_stall) begin
                chk("stall_out",   out_a,       saved_out);
                chk("stall_index", 64'(idx_a),  64'(saved_idx));
                chk("stall_valid", 64'(valid_a), 64'd1);
            end
            if (valid_a) begin
                ready_a = 1'($urandom_range(0, 1));
                if (ready_a) begin
                    chk("bp_index", 64'(idx_a), 64'(exp_idx));
                    chk("bp_key",   out_a, mdl_rk(80, 128'd0, exp_idx));
                    chk("bp_last",  64'(last_a), (exp_idx == 31) ? 64'd1 : 64'd0);
                    if (exp_idx == 31) done = 1'b1;
                    exp_idx++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    saved_out  = out_a;
                    saved_idx  = idx_a;
                end
            end else begin
                ready_a    = 1'($urandom_range(0, 1));
                prev_stall = 1'b0;
            end
        end
        chk("bp_completed", 64'(done), 64'd1);
        @(posedge clock); #1;
        chk("bp_end_valid", 64'(valid_a), 64'd0);
        ready_a = 1'b1;

        // 80-bit, key 0, reverse: expansion then K32..K1.
        start_a = 1'b1; decrypt_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0; decrypt_a = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clock); #1;
            chk("exp_novalid", 64'(valid_a), 64'd0);
            chk("exp_busy",    64'(busy_a),  64'd1);
        end
        for (int i = 31; i >= 0; i--) begin
            @(posedge clock); #1;
            chk("rev_valid", 64'(valid_a), 64'd1);
            chk("rev_index", 64'(idx_a), 64'(i));
            chk("rev_key",   out_a, mdl_rk(80, 128'd0, i));
            chk("rev_last",  64'(last_a), (i == 0) ? 64'd1 : 64'd0);
        end
        @(posedge clock); #1;
        chk("rev_end_valid", 64'(valid_a), 64'd0);
        chk("rev_end_busy",  64'(busy_a),  64'd0);

        // 128-bit, key 0, forward, with an ignored start pulse at index 5.
        start_b = 1'b1; decrypt_b = 1'b0; key_b = '0; ready_b = 1'b1;
        @(posedge clock); #1;
        start_b = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clock); #1;
            chk("w_index", 64'(idx_b), 64'(i));
            chk("w_key",   out_b, mdl_rk(128, 128'd0, i));
            chk("w_last",  64'(last_b), (i == 31) ? 64'd1 : 64'd0);
            if (i == 0) chk("w_k1", out_b, 64'h0000000000000000);
            if (i == 1) chk("w_k2", out_b, 64'hCC00000000000000);
            if (i == 5) begin
                start_b = 1'b1; decrypt_b = 1'b1; key_b = '1;
            end else begin
                start_b = 1'b0; decrypt_b = 1'b0; key_b = '0;
            end
        end
        @(posedge clock); #1;
        chk("w_end_valid", 64'(valid_b), 64'd0);
        chk("w_end_busy",  64'(busy_b),  64'd0);

        // Reset mid-stream at index 10, then a clean restart with all-ones key.
        start_a = 1'b1; decrypt_a = 1'b0; key_a = '0; ready_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(posedge clock); #1;
        end
        chk("mid_index", 64'(idx_a), 64'd10);
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("mid_rst_valid", 64'(valid_a), 64'd0);
        chk("mid_rst_busy",  64'(busy_a),  64'd0);
        reset_n = 1'b1;
        start_a = 1'b1; key_a = '1;
        @(posedge clock); #1;
        start_a = 1'b0; key_a = '0;
        @(posedge clock); #1;
        chk("ff_valid", 64'(valid_a), 64'd1);
        chk("ff_index", 64'(idx_a), 64'd0);
        chk("ff_k1",    out_a, 64'hFFFFFFFFFFFFFFFF);
        @(posedge clock); #1;
        chk("ff_k2",    out_a, mdl_rk(80, {48'd0, {80{1'b1}}}, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/present_key_scheduler.md
# present_key_scheduler

Parametrised PRESENT key schedule that expands an 80- or 128-bit cipher key into `ROUNDS` 64-bit round keys. Keys stream out over a valid/ready handshake, in forward order for encryption or reverse order for decryption. For decryption the block first expands the whole schedule into an internal round-key buffer. It sits between key loading and the PRESENT round datapath, and replaces per-round external counter driving with an internally sequenced schedule.

## Interface
Parameters:
- `KEY_WIDTH`, 80: cipher key width; legal values are 80 or 128.
- `ROUNDS`, 32: number of round keys produced; range 2..32.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `key_in`  in  KEY_WIDTH  cipher key; sampled only when `start` is accepted.
- `start`  in  1  request a schedule; accepted only when `busy`=0.
- `decrypt`  in  1  order select, sampled with `start`: 0 streams K1..K_ROUNDS, 1 streams K_ROUNDS..K1.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle after the last handshake.
- `rk_valid`  out  1  `rk_out` holds a round key.
- `rk_ready`  in  1  consumer accepts `rk_out`.
- `rk_out`  out  64  round key.
- `rk_index`  out  5  0-based round number of `rk_out`; K1 has index 0.
- `rk_last`  out  1  high with the final key of the sequence.

## Operation
- State machine: IDLE, EXPAND, STREAM_FWD, STREAM_REV.
- IDLE with `start`=1:
  - latch `key_in` into the key register;
  - clear the round counter;
  - go to STREAM_FWD if `decrypt`=0, otherwise EXPAND.
- Round key K_i is the top 64 bits of the key register: `[79:16]` when KEY_WIDTH=80, `[127:64]` when KEY_WIDTH=128.
- Update from K_i to K_{i+1}, with i running 1..ROUNDS-1:
  1. Rotate the register left by 61.
  2. Apply the S-box to the top nibble (80-bit) or to the top two nibbles (128-bit).
  3. XOR i (5 bits) into `[19:15]` (80-bit) or `[66:62]` (128-bit).
- S-box, inputs 0..F map to outputs C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- STREAM_FWD:
  - `rk_valid`=1 with the current key;
  - on `rk_valid & rk_ready`, apply the update and increment `rk_index`;
  - after the handshake with `rk_index`=ROUNDS-1, go to IDLE.
- EXPAND:
  - write K1..K_ROUNDS into the buffer, one per cycle, applying the update between writes;
  - after writing K_ROUNDS, go to STREAM_REV.
- STREAM_REV:
  - the buffer is read with registered output;
  - the read address starts at ROUNDS-1 and decrements on each handshake; the next word is prefetched so the stream has no bubbles;
  - after the handshake with index 0, go to IDLE.
- `rk_last` = `rk_valid` & (`rk_index`=ROUNDS-1 when forward, or `rk_index`=0 when reverse).
- Backpressure: while `rk_valid` & !`rk_ready`, the block holds `rk_out`, `rk_index` and `rk_last` stable.
- `start` while `busy`=1 is ignored. Changes to `key_in` or `decrypt` while busy have no effect.

## Timing
- Reset values: state IDLE; `busy`, `rk_valid`, `rk_last` = 0; `rk_out`, `rk_index` = 0. The buffer contents are not reset.
- Reset has priority over every event. Reset mid-operation drops `rk_valid` and `busy` at the next edge, and the partial sequence is discarded. A `start` in a reset cycle is ignored.
- Forward: `start` sampled at edge 0; `rk_valid` with K1 is high after edge 1. With `rk_ready` held at 1, one key per cycle; the last key is valid after edge ROUNDS.
- Reverse:
  - EXPAND occupies edges 1..ROUNDS;
  - `rk_valid` with K_ROUNDS is high after edge ROUNDS+1;
  - with `rk_ready`=1, one key per cycle thereafter.
- After the final handshake at edge n: `rk_valid`=0 and `busy`=0 after edge n, and a new `start` is accepted in that same following cycle.
- Index arithmetic is 5-bit with no wrap. Counter values beyond ROUNDS-1 are unreachable.

## Structure
- Shared package `present_pkg`:
  - S-box constant;
  - state enum;
  - function `present_key_update(key, counter)`, specialised on KEY_WIDTH;
  - `RK_WIDTH`=64.
- Sub-module `present_rk_buffer`: ROUNDS×64 register file with one write port and one registered read port. It is instantiated once and used only by the reverse path.
- An elaboration-time check rejects KEY_WIDTH outside {80,128} and ROUNDS outside 2..32.

## Test plan
- Reset held for 3 cycles with `start`=1 → all outputs 0, `busy`=0, no `rk_valid`.
- KEY_WIDTH=80, key 0, forward, `rk_ready`=1 → index 0 = 0000000000000000, index 1 = C000000000000000, index 2 = 5000180000000001. Expect 32 keys on consecutive cycles and `rk_last` only at index 31.
- Same run with `rk_ready` toggled pseudo-randomly → identical key sequence; `rk_out` and `rk_index` are stable on every stalled cycle.
- KEY_WIDTH=80, key 0, reverse → first `rk_valid` after edge 33 with the index-31 key captured in the forward run. Then indices 30..0 follow, and the last key is 0000000000000000 with `rk_last`=1.
- KEY_WIDTH=128, key 0, forward → index 0 = 0000000000000000, index 1 = CC00000000000000. A `start` pulsed at index 5 is ignored and the sequence completes normally.
- Reset asserted at forward index 10 → `rk_valid`=0 and `busy`=0 next cycle. A new `start` with key FFFF…F then begins cleanly with index 0 = FFFFFFFFFFFFFFFF.
